// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg : state codes, field widths and helpers shared by the game flow
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  localparam int LEVEL_W        = 2;
  localparam int LIVES_W        = 2;
  localparam int SCORE_W        = 16;
  localparam int NUM_LEVELS_DEF = 4;

  // Codes are fixed by the renderer; 7 is unused.
  typedef enum logic [2:0] {
    S_RUNNING   = 3'd0,
    S_GAME_OVER = 3'd1,
    S_WIN       = 3'd2,
    S_TITLE     = 3'd3,
    S_DYING     = 3'd4,
    S_LOAD      = 3'd5,
    S_FINISHED  = 3'd6
  } state_e;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_flow_controller_tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer : loadable tick countdown, expire flags a count of 1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expire_o
);

  logic [W-1:0] count_q, count_d;

  // A zero load would never expire, so it is promoted to a one-tick hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = (load_val_i == '0) ? W'(1) : load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign expire_o = (count_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/game_flow_controller.sv
// ---------------------------------------------------------------------------
// game_flow_controller : game state, level, lives, score and respawn sequencer
// Optional macro GAME_FLOW_CHECKPOINT_EN keeps the level on game-over restart.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_flow_controller
  import game_pkg::*;
#(
  parameter int NUM_LEVELS  = NUM_LEVELS_DEF,
  parameter int START_LIVES = 3,
  parameter int DEATH_TICKS = 90,
  parameter int CLEAR_TICKS = 120,
  parameter int TIMER_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_tick,
  input  logic               start_btn,
  input  logic               in_lava,
  input  logic               at_goal_region,
  input  logic               jump_landed_pulse,
  output logic [2:0]         game_state,
  output logic               freeze,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               respawn_pulse,
  output logic               lava_reset_pulse,
  output logic               lava_boost_pulse
);

  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

  state_e               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 jump_seen_q, jump_seen_d;
  logic                 freeze_q;
  logic                 respawn_q, respawn_d;
  logic                 lava_reset_q, lava_reset_d;
  logic                 boost_q, boost_d;

  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_val;
  logic                 tmr_dec;
  logic                 tmr_expire;

  tick_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    score_d      = score_q;
    jump_seen_d  = 1'b0;
    respawn_d    = 1'b0;
    lava_reset_d = 1'b0;
    boost_d      = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_dec      = 1'b0;

    // Landings between ticks are remembered only while the player is live.
    if (state_q == S_RUNNING) jump_seen_d = jump_seen_q | jump_landed_pulse;

    if (game_tick) begin
      jump_seen_d = 1'b0;
      case (state_q)
        S_TITLE: begin
          if (start_btn) state_d = S_LOAD;
        end
        S_LOAD: begin
          respawn_d    = 1'b1;
          lava_reset_d = 1'b1;
          state_d      = S_RUNNING;
        end
        S_RUNNING: begin
          if (in_lava) begin
            if (lives_q > LIVES_W'(1)) begin
              lives_d  = lives_q - LIVES_W'(1);
              tmr_load = 1'b1;
              tmr_val  = TIMER_W'(DEATH_TICKS);
              state_d  = S_DYING;
            end else begin
              lives_d = '0;
              state_d = S_GAME_OVER;
            end
          end else if (at_goal_region) begin
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(CLEAR_TICKS);
            state_d  = S_WIN;
          end
          if (jump_seen_q || jump_landed_pulse) begin
            score_d = score_inc(score_q);
            boost_d = 1'b1;
          end
        end
        S_DYING: begin
          tmr_dec = 1'b1;
          if (tmr_expire) state_d = S_LOAD;
        end
        S_WIN: begin
          tmr_dec = 1'b1;
          if (tmr_expire) begin
            if (level_q == LAST_LEVEL) begin
              state_d = S_FINISHED;
            end else begin
              level_d = level_q + LEVEL_W'(1);
              state_d = S_LOAD;
            end
          end
        end
        S_GAME_OVER: begin
          if (start_btn) begin
`ifdef GAME_FLOW_CHECKPOINT_EN
            level_d = level_q;
`else
            level_d = '0;
`endif
            lives_d = LIVES_INIT;
            score_d = '0;
            state_d = S_LOAD;
          end
        end
        S_FINISHED: begin
          if (start_btn) begin
            level_d = '0;
            lives_d = LIVES_INIT;
            score_d = '0;
            state_d = S_LOAD;
          end
        end
        default: state_d = S_TITLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_TITLE;
      level_q      <= '0;
      lives_q      <= LIVES_INIT;
      score_q      <= '0;
      jump_seen_q  <= 1'b0;
      freeze_q     <= 1'b1;
      respawn_q    <= 1'b0;
      lava_reset_q <= 1'b0;
      boost_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      jump_seen_q  <= jump_seen_d;
      freeze_q     <= (state_d != S_RUNNING);
      respawn_q    <= respawn_d;
      lava_reset_q <= lava_reset_d;
      boost_q      <= boost_d;
    end
  end

  assign game_state       = state_q;
  assign freeze           = freeze_q;
  assign level            = level_q;
  assign lives            = lives_q;
  assign score            = score_q;
  assign respawn_pulse    = respawn_q;
  assign lava_reset_pulse = lava_reset_q;
  assign lava_boost_pulse = boost_q;

endmodule

`default_nettype wire

// File: tb/tb_game_flow_controller.sv
// ---------------------------------------------------------------------------
// tb_game_flow_controller : directed scenarios plus random stimulus vs model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_flow_controller;

  localparam int NL    = 4;
  localparam int SL    = 3;
  localparam int DEATH = 90;
  localparam int CLEAR = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_tick = 1'b0, start_btn = 1'b0, in_lava = 1'b0;
  logic        at_goal_region = 1'b0, jump_landed_pulse = 1'b0;
  logic [2:0]  game_state;
  logic        freeze;
  logic [1:0]  level, lives;
  logic [15:0] score;
  logic        respawn_pulse, lava_reset_pulse, lava_boost_pulse;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: state codes as plain ints, ticks remaining in a timed state.
  int m_state, m_level, m_lives, m_score, m_left;
  bit m_jump, m_resp, m_lres, m_boost;

  game_flow_controller #(
    .NUM_LEVELS  (NL),
    .START_LIVES (SL),
    .DEATH_TICKS (DEATH),
    .CLEAR_TICKS (CLEAR),
    .TIMER_W     (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .game_tick         (game_tick),
    .start_btn         (start_btn),
    .in_lava           (in_lava),
    .at_goal_region    (at_goal_region),
    .jump_landed_pulse (jump_landed_pulse),
    .game_state        (game_state),
    .freeze            (freeze),
    .level             (level),
    .lives             (lives),
    .score             (score),
    .respawn_pulse     (respawn_pulse),
    .lava_reset_pulse  (lava_reset_pulse),
    .lava_boost_pulse  (lava_boost_pulse)
  );

  always #5 clk = ~clk;

  task automatic restart_game(input bit keep_level);
    if (!keep_level) m_level = 0;
    m_lives = SL;
    m_score = 0;
    m_state = 5;
  endtask

  task automatic model_clk(input bit r, input bit tk, input bit st, input bit lv,
                           input bit gl, input bit jp);
    bit landed;
    m_resp = 0; m_lres = 0; m_boost = 0;
    if (!r) begin
      m_state = 3; m_level = 0; m_lives = SL; m_score = 0; m_left = 0; m_jump = 0;
      return;
    end
    if (!tk) begin
      m_jump = (m_state == 0) && (m_jump || jp);
      return;
    end
    landed = (m_state == 0) && (m_jump || jp);
    m_jump = 0;
    case (m_state)
      3: if (st) m_state = 5;
      5: begin m_resp = 1; m_lres = 1; m_state = 0; end
      0: begin
        if (lv) begin
          if (m_lives > 1) begin
            m_lives = m_lives - 1;
            m_left  = (DEATH < 1) ? 1 : DEATH;
            m_state = 4;
          end else begin
            m_lives = 0;
            m_state = 1;
          end
        end else if (gl) begin
          m_left  = (CLEAR < 1) ? 1 : CLEAR;
          m_state = 2;
        end
        if (landed) begin
          m_score = (m_score < 65535) ? m_score + 1 : 65535;
          m_boost = 1;
        end
      end
      4: begin
        if (m_left == 1) m_state = 5;
        m_left = m_left - 1;
      end
      2: begin
        if (m_left == 1) begin
          if (m_level == NL - 1) m_state = 6;
          else begin m_level = m_level + 1; m_state = 5; end
        end
        m_left = m_left - 1;
      end
`ifdef GAME_FLOW_CHECKPOINT_EN
      1: if (st) restart_game(1'b1);
`else
      1: if (st) restart_game(1'b0);
`endif
      6: if (st) restart_game(1'b0);
      default: m_state = 3;
    endcase
  endtask

  function automatic logic [26:0] dut_vec();
    return {game_state, freeze, level, lives, score,
            respawn_pulse, lava_reset_pulse, lava_boost_pulse};
  endfunction

  function automatic logic [26:0] exp_vec();
    return {3'(m_state), (m_state != 0), 2'(m_level), 2'(m_lives), 16'(m_score),
            m_resp, m_lres, m_boost};
  endfunction

  task automatic step(input bit tk, input bit st, input bit lv, input bit gl, input bit jp);
    @(negedge clk);
    game_tick = tk; start_btn = st; in_lava = lv; at_goal_region = gl; jump_landed_pulse = jp;
    @(posedge clk);
    model_clk(rst, tk, st, lv, gl, jp);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (dut_vec() !== {3'd3, 1'b1, 2'd0, 2'd3, 16'd0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec(), {3'd3, 1'b1, 2'd0, 2'd3, 16'd0, 3'b000});
    end
  endtask

  task automatic test_start();
    step(1, 1, 0, 0, 0);
    n_vec++;
    if ({game_state, freeze} !== {3'd5, 1'b1}) begin
      n_bad++; $display("FAIL start_to_load got=%0d/%b exp=5/1", game_state, freeze);
    end
    step(1, 0, 0, 0, 0);
    n_vec++;
    if ({game_state, freeze, respawn_pulse, lava_reset_pulse} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL load_to_run got=%0d/%b/%b/%b exp=0/0/1/1",
                        game_state, freeze, respawn_pulse, lava_reset_pulse);
    end
    step(0, 0, 0, 0, 0);
    n_vec++;
    if ({respawn_pulse, lava_reset_pulse} !== 2'b00 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL load_pulse_width got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_death();
    step(1, 0, 1, 0, 0);
    n_vec++;
    if ({game_state, lives, freeze} !== {3'd4, 2'd2, 1'b1}) begin
      n_bad++; $display("FAIL death_enter got=%0d/%0d exp=4/2", game_state, lives);
    end
    ticks(DEATH - 1);
    n_vec++;
    if (game_state !== 3'd4) begin
      n_bad++; $display("FAIL dying_hold got=%0d exp=4", game_state);
    end
    step(1, 0, 0, 0, 0);
    n_vec++;
    if (game_state !== 3'd5) begin
      n_bad++; $display("FAIL dying_expire got=%0d exp=5", game_state);
    end
    step(1, 0, 0, 0, 0);
    n_vec++;
    if ({game_state, level, respawn_pulse} !== {3'd0, 2'd0, 1'b1} || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL respawn got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_lava_priority();
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 1, 0);
    n_vec++;
    if ({game_state, lives, score, lava_boost_pulse} !== {3'd4, 2'd1, 16'd1, 1'b1}) begin
      n_bad++; $display("FAIL lava_beats_goal got=%0d/%0d/%0d/%b exp=4/1/1/1",
                        game_state, lives, score, lava_boost_pulse);
    end
    step(0, 0, 0, 0, 0);
    n_vec++;
    if (lava_boost_pulse !== 1'b0) begin
      n_bad++; $display("FAIL boost_width got=%b exp=0", lava_boost_pulse);
    end
    ticks(DEATH + 1);
    n_vec++;
    if (dut_vec() !== exp_vec() || game_state !== 3'd0) begin
      n_bad++; $display("FAIL lava_recover got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_win();
    for (int lv = 0; lv < NL; lv++) begin
      step(1, 0, 0, 1, 0);
      n_vec++;
      if (game_state !== 3'd2) begin
        n_bad++; $display("FAIL win_enter lvl=%0d got=%0d exp=2", lv, game_state);
      end
      ticks(CLEAR);
      n_vec++;
      if (lv < NL - 1) begin
        if ({game_state, level} !== {3'd5, 2'(lv + 1)}) begin
          n_bad++; $display("FAIL win_next got=%0d/%0d exp=5/%0d", game_state, level, lv + 1);
        end
        step(1, 0, 0, 0, 0);
      end else if ({game_state, level} !== {3'd6, 2'd3}) begin
        n_bad++; $display("FAIL win_finished got=%0d/%0d exp=6/3", game_state, level);
      end
    end
    step(1, 1, 0, 0, 0);
    n_vec++;
    if ({game_state, level, lives, score} !== {3'd5, 2'd0, 2'd3, 16'd0}) begin
      n_bad++; $display("FAIL finished_restart got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_game_over();
    step(1, 0, 0, 1, 0);
    ticks(CLEAR + 1);
    for (int d = 0; d < SL - 1; d++) begin
      step(1, 0, 1, 0, 0);
      ticks(DEATH + 1);
    end
    step(1, 0, 1, 0, 1);
    n_vec++;
    if ({game_state, freeze, lives, level, score} !== {3'd1, 1'b1, 2'd0, 2'd1, 16'd1}) begin
      n_bad++; $display("FAIL game_over got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(1, 0, 0, 0, 0);
    n_vec++;
    if (game_state !== 3'd1) begin
      n_bad++; $display("FAIL game_over_hold got=%0d exp=1", game_state);
    end
    step(1, 1, 0, 0, 0);
    n_vec++;
`ifdef GAME_FLOW_CHECKPOINT_EN
    if ({game_state, level, lives, score} !== {3'd5, 2'd1, 2'd3, 16'd0}) begin
`else
    if ({game_state, level, lives, score} !== {3'd5, 2'd0, 2'd3, 16'd0}) begin
`endif
      n_bad++; $display("FAIL game_over_restart got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(1499, 0) == 0) rst = 1'b0;
      step(($urandom_range(2, 0) == 0), ($urandom_range(7, 0) == 0),
           ($urandom_range(39, 0) == 0), ($urandom_range(49, 0) == 0),
           ($urandom_range(3, 0) == 0));
      rst = 1'b1;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_score_saturation();
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step(1, 0, 0, 0, 1);
    n_vec++;
    if (score !== 16'hFFFF) begin
      n_bad++; $display("FAIL score_reach_max got=%h exp=ffff", score);
    end
    step(1, 0, 0, 0, 1);
    n_vec++;
    if ({score, lava_boost_pulse} !== {16'hFFFF, 1'b1} || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL score_saturate got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(0, 0, 0, 0, 0);
    n_vec++;
    if (lava_boost_pulse !== 1'b0) begin
      n_bad++; $display("FAIL boost_clear got=%b exp=0", lava_boost_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_death();
    test_lava_priority();
    test_win();
    test_game_over();
    test_random();
    test_score_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
